// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/soft-stop duty ramp controller driving the PWM timer's mode and compare value
module pwm_ramp_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] target_duty,
    input  logic [WIDTH-1:0] step_size,
    input  logic [WIDTH-1:0] step_interval,
    input  logic [WIDTH-1:0] max_count,
    output logic [1:0]       control,
    output logic [WIDTH-1:0] compare,
    output logic             at_target,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] tick_cnt, eff_target, goal, step, dn_dif, stepped, cmp_n;
    logic [WIDTH:0]   up_sum;
    logic             tick;
    // next state and next compare; a tick moves compare one saturating step toward the goal
    always_comb begin
        eff_target = target_duty > max_count ? max_count : target_duty;
        step       = step_size == '0 ? WIDTH'(1) : step_size;
        tick       = tick_cnt >= step_interval;
        goal       = state == STOP ? '0 : eff_target;
        up_sum     = {1'b0, compare} + {1'b0, step};
        dn_dif     = compare - step;
        stepped    = compare < goal ? (up_sum > {1'b0, goal} ? goal : up_sum[WIDTH-1:0])
                                    : (compare < step || dn_dif < goal ? goal : dn_dif);
        state_n    = state;
        cmp_n      = compare;
        case (state)
            IDLE: begin
                cmp_n   = '0;
                state_n = enable ? RAMP : IDLE;
            end
            RAMP: begin
                if (!enable) state_n = STOP;
                else if (compare == eff_target) state_n = HOLD;
                else if (tick) cmp_n = stepped;
            end
            HOLD: state_n = !enable ? STOP : (eff_target != compare ? RAMP : HOLD);
            STOP: begin
                if (enable) state_n = RAMP;
                else begin
                    cmp_n   = tick ? stepped : compare;
                    state_n = cmp_n == '0 ? IDLE : STOP;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // registered outputs derived from the next state so the timer mode only flips on IDLE entry/exit
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            control   <= 2'b00;
            compare   <= '0;
            at_target <= 1'b0;
            busy      <= 1'b0;
            tick_cnt  <= '0;
        end else begin
            state     <= state_n;
            compare   <= cmp_n;
            control   <= state_n == IDLE ? 2'b00 : 2'b10;
            at_target <= state_n == HOLD;
            busy      <= state_n != IDLE;
            tick_cnt  <= (state == IDLE || tick) ? '0 : tick_cnt + WIDTH'(1);
        end
    end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Soft-start/soft-stop duty controller sitting directly upstream of the PWM timer counter in the elevator motor path. Drives the timer's control mode and compare value so that duty ramps linearly toward a software-set target at a programmable rate. It never steps the duty abruptly, and it ramps down to zero before switching the timer off. max_count is shared with the timer and is used only for clamping.

Parameters:
- WIDTH, 16, width of duty/compare/max_count/step fields; must match the timer's 16-bit fields.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  level; 1 = run motor PWM, 0 = ramp down and stop
- target_duty  input  WIDTH  requested compare value
- step_size  input  WIDTH  compare increment/decrement per tick; 0 is treated as 1
- step_interval  input  WIDTH  clocks between ticks minus 1; 0 = tick every clock
- max_count  input  WIDTH  timer period value, same net as the timer's max_count
- control  output  2  timer mode: 2'b00 off, 2'b10 PWM
- compare  output  WIDTH  duty compare value to the timer
- at_target  output  1  compare equals the effective target in HOLD
- busy  output  1  high in any state except IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, control=2'b00, compare=0, at_target=0, busy=0, tick_cnt=0.
- eff_target = (target_duty > max_count) ? max_count : target_duty. It is evaluated combinationally every cycle.
- Tick generator:
  - tick_cnt counts 0..step_interval.
  - tick is asserted when tick_cnt==step_interval; tick_cnt then returns to 0.
  - tick_cnt is held at 0 in IDLE, so the first tick after leaving IDLE occurs step_interval+1 clocks after the transition.
- Step arithmetic uses WIDTH+1 bits:
  - Up: compare <= min(compare+step, goal).
  - Down: compare <= (compare < step) ? goal : max(compare-step, goal).
  - No wrap-around in either direction.
- States:
  - IDLE: control=00, compare=0. If enable=1, go to RAMP next clock with control=10, busy=1.
  - RAMP (goal=eff_target), evaluated in priority order:
    - enable=0: go to STOP.
    - compare==eff_target: go to HOLD with at_target=1.
    - Otherwise: step on tick.
  - HOLD: at_target=1, compare is frozen.
    - enable=0: go to STOP with at_target=0.
    - eff_target != compare (target or max_count changed): go to RAMP with at_target=0 on the same clock edge.
  - STOP (goal=0): steps down on tick.
    - enable=1: go to RAMP.
    - compare==0: go to IDLE with control=00 and busy=0 on the same clock edge.
- control changes only on IDLE→RAMP and STOP→IDLE. The timer resets its counter on any mode change, so mode toggling must not happen elsewhere.
- target_duty changing mid-RAMP takes effect at the next tick. Direction reverses if needed.
- max_count dropping below the current compare: eff_target drops and compare ramps down to it. No instantaneous clamp.
- enable=1 with eff_target=0: IDLE→RAMP→HOLD. control=10 with compare=0 (0% duty).
- Reset asserted mid-ramp: all state and outputs return to reset values on the next clock edge, including control=00 immediately.

Test Plan:
- Reset release, enable=0 for 20 clk → control=00, compare=0, busy=0, at_target=0 throughout.
- max_count=999, target=500, step=100, interval=3, enable↑ → control=10 one clk later; compare 100,200,300,400,500 at 4-clk spacing; at_target=1 one clk after reaching 500.
- Ramp-up as above to 500, then target=430, step=100 → compare steps to 430 (clamped, no undershoot), HOLD re-entered, at_target=1.
- In HOLD at 500, enable↓ with step=100, interval=0 → compare 400,300,200,100,0 on consecutive clocks; control=00 and busy=0 on the clock compare reaches 0.
- target=2000, max_count=999, step=600, interval=0 → compare 600,999 (saturated), HOLD. Then max_count=499 → ramps down to 499 and returns to HOLD.
- Ramp in progress at compare=300, reset pulsed for 1 clk → compare=0, control=00, busy=0, at_target=0 on the next edge. With enable still high, RAMP restarts from 0.
